sc_rr_slave_mem: RTL and testbench

- Memory-mapped bus responder for one crossbar slave port (req/addr/cmd/wdata in, ack/rdata out).
- Backs a word-addressed single-port RAM with a fixed, parameterised number of wait states.
- Serves as the standard slave model and real on-chip scratch memory behind the round-robin crossbar.
- Out-of-window accesses are acknowledged with error data and counted, so no master is ever left hung.

---
 rtl/sc_rr_slave_mem_pkg.sv | 20 ++
 rtl/sc_rr_sram.sv | 27 ++
 rtl/sc_rr_slave_mem.sv | 135 +++++++++++++
 tb/tb_sc_rr_slave_mem.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_rr_slave_mem_pkg.sv
// rtl/sc_rr_slave_mem_pkg.sv - shared encodings and constants for the crossbar slave memory
package sc_rr_slave_mem_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Default error pattern, also used by the crossbar and its bench.
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sc_rr_sram.sv
// rtl/sc_rr_sram.sv - single-port write-first synchronous RAM, no reset so it maps to block RAM
module sc_rr_sram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sc_rr_slave_mem.sv
// rtl/sc_rr_slave_mem.sv - crossbar slave port backed by a wait-stated scratch RAM
module sc_rr_slave_mem
  import sc_rr_slave_mem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_DATA    = DEFAULT_ERR_DATA
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_cmd,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t          state;
  logic [3:0]      wcnt;
  logic [AW-1:0]   cap_idx;
  logic            cap_cmd;
  logic            cap_hit;
  logic [31:0]     cap_wdata;
  logic [31:0]     rdata_hold;
  logic            use_ram;
  logic [31:0]     ram_q;

  logic            in_idle;
  logic            live_hit;
  logic [AW-1:0]   live_idx;
  logic            cur_hit;
  logic            cur_cmd;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            enter_ack;
  logic            ram_en;
  logic            ram_we;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];

  assign in_idle  = (state == ST_IDLE);
  assign live_hit = (i_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign live_idx = i_addr[AW+1:2];

  // With zero wait states the ACK transition happens on the capture edge, so use live inputs.
  assign cur_hit   = in_idle ? live_hit : cap_hit;
  assign cur_cmd   = in_idle ? i_cmd    : cap_cmd;
  assign cur_idx   = in_idle ? live_idx : cap_idx;
  assign cur_wdata = in_idle ? i_wdata  : cap_wdata;

  assign enter_ack = in_idle ? (i_req && (WAIT_CYCLES == 0))
                             : ((state == ST_WAIT) && (wcnt == 4'd1));

  assign ram_en = enter_ack & cur_hit & ~i_reset;
  assign ram_we = ram_en & (cur_cmd == CMD_WRITE);

  // Hit reads are served straight from the RAM output register, which holds until the next enable.
  assign o_rdata = use_ram ? ram_q : rdata_hold;

  sc_rr_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (i_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      wcnt       <= 4'd0;
      cap_idx    <= '0;
      cap_cmd    <= 1'b0;
      cap_hit    <= 1'b0;
      cap_wdata  <= 32'd0;
      o_ack      <= 1'b0;
      o_busy     <= 1'b0;
      o_err_cnt  <= 8'd0;
      rdata_hold <= 32'd0;
      use_ram    <= 1'b0;
    end else begin
      o_ack <= enter_ack;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            cap_idx   <= live_idx;
            cap_cmd   <= i_cmd;
            cap_hit   <= live_hit;
            cap_wdata <= i_wdata;
            wcnt      <= WAIT_INIT;
            o_busy    <= 1'b1;
            state     <= enter_ack ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (enter_ack) state <= ST_ACK;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase

      if (enter_ack) begin
        if (!cur_hit) begin
          o_err_cnt <= sat_inc8(o_err_cnt);
          if (cur_cmd == CMD_READ) begin
            rdata_hold <= ERR_DATA;
            use_ram    <= 1'b0;
          end
        end else if (cur_cmd == CMD_READ) begin
          use_ram <= 1'b1;
        end else begin
          // The write-first RAM output is about to change; freeze the visible value first.
          rdata_hold <= o_rdata;
          use_ram    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_rr_slave_mem.sv
// tb/tb_sc_rr_slave_mem.sv - self-checking bench for sc_rr_slave_mem
module tb_sc_rr_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, cmd, req0, cmd0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic        ack, busy, ack0, busy0;
  logic [31:0] rdata, rdata0;
  logic [7:0]  err, err0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sc_rr_slave_mem dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_cmd(cmd), .i_wdata(wdata),
    .o_ack(ack), .o_rdata(rdata), .o_busy(busy), .o_err_cnt(err)
  );

  sc_rr_slave_mem #(.WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_req(req0), .i_addr(addr0), .i_cmd(cmd0), .i_wdata(wdata0),
    .o_ack(ack0), .o_rdata(rdata0), .o_busy(busy0), .o_err_cnt(err0)
  );

  // Reference model of the default-parameter instance: window 0..0x3FF, 256 words.
  logic [31:0] mmem [256];
  bit          mwr  [256];
  int          merr;
  logic [31:0] mrd;

  task automatic model(input logic [31:0] a, input logic c, input logic [31:0] d);
    int idx;
    idx = int'(a[9:2]);
    if (a[31:10] == 22'd0) begin
      if (c) begin
        mmem[idx] = d;
        mwr[idx]  = 1'b1;
      end else begin
        mrd = mmem[idx];
      end
    end else begin
      if (merr < 255) merr = merr + 1;
      if (!c) mrd = 32'hDEAD_BEEF;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One transaction on the selected instance; reports latency in edges and control-signal sanity.
  task automatic txn(input bit sel, input logic [31:0] a, input logic c, input logic [31:0] d,
                     input bit drop, output logic [31:0] rd, output logic [7:0] ec,
                     output int lat, output bit ctl_ok);
    bit got;
    got = 1'b0;
    lat = 0;
    ctl_ok = 1'b1;
    if (sel) begin req0 = 1'b1; addr0 = a; cmd0 = c; wdata0 = d; end
    else     begin req  = 1'b1; addr  = a; cmd  = c; wdata  = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (drop && lat == 1) begin
        req = 1'b0;
        addr = 32'hFFFF_FFFF;
        wdata = 32'h0;
        cmd = 1'b0;
      end
      if (!(sel ? busy0 : busy)) ctl_ok = 1'b0;
      if (sel ? ack0 : ack) got = 1'b1;
    end
    if (!got) lat = -1;
    rd = sel ? rdata0 : rdata;
    ec = sel ? err0 : err;
    req = 1'b0;
    req0 = 1'b0;
    @(posedge clk); #1;
    if ((sel ? ack0 : ack) || (sel ? busy0 : busy)) ctl_ok = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [31:0] rd;
    logic [7:0]  ec;
    int          lat;
    bit          ok;
    bit          bad;
    int          k, cyc, last;

    vt[0] = '{32'h0000_0010, 1'b1, 32'h1234_5678, 32'h0000_0000, 8'd0};
    vt[1] = '{32'h0000_0010, 1'b0, 32'h0,         32'h1234_5678, 8'd0};
    vt[2] = '{32'h0000_0400, 1'b0, 32'h0,         32'hDEAD_BEEF, 8'd1};
    vt[3] = '{32'h0000_03FC, 1'b1, 32'h0000_00A5, 32'hDEAD_BEEF, 8'd1};
    vt[4] = '{32'h0000_03FD, 1'b0, 32'h0,         32'h0000_00A5, 8'd1};
    vt[5] = '{32'h0000_0004, 1'b1, 32'h0000_0055, 32'h0000_00A5, 8'd1};
    vt[6] = '{32'h0000_0404, 1'b1, 32'h0000_0077, 32'h0000_00A5, 8'd2};
    vt[7] = '{32'h0000_0004, 1'b0, 32'h0,         32'h0000_0055, 8'd2};
    vt[8] = '{32'h0000_07FC, 1'b0, 32'h0,         32'hDEAD_BEEF, 8'd3};

    for (int i = 0; i < 256; i++) begin mmem[i] = 32'h0; mwr[i] = 1'b0; end
    merr = 0;
    mrd  = 32'h0;

    rst = 1'b1;
    req = 1'b0; addr = 32'h0; cmd = 1'b0; wdata = 32'h0;
    req0 = 1'b0; addr0 = 32'h0; cmd0 = 1'b0; wdata0 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_ack",   {31'd0, ack},  32'd0);
    check("reset_rdata", rdata,         32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_err",   {24'd0, err},  32'd0);
    check("reset_err0",  {24'd0, err0}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      txn(1'b0, vt[i].addr, vt[i].cmd, vt[i].wdata, 1'b0, rd, ec, lat, ok);
      model(vt[i].addr, vt[i].cmd, vt[i].wdata);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_busy_ack", i), {31'd0, ok}, 32'd1);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {24'd0, ec}, {24'd0, vt[i].exp_err});
    end

    // Reset while a write sits in WAIT: no ack, no write.
    txn(1'b0, 32'h20, 1'b1, 32'h11, 1'b0, rd, ec, lat, ok);
    model(32'h20, 1'b1, 32'h11);
    req = 1'b1; addr = 32'h20; cmd = 1'b1; wdata = 32'h99;
    @(posedge clk); #1;
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ack",   {31'd0, ack},  32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_err",   {24'd0, err},  32'd0);
    check("rst_rdata", rdata,         32'd0);
    merr = 0;
    mrd  = 32'h0;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) bad = 1'b1;
    end
    check("rst_no_late_ack", {31'd0, bad}, 32'd0);
    txn(1'b0, 32'h20, 1'b0, 32'h0, 1'b0, rd, ec, lat, ok);
    model(32'h20, 1'b0, 32'h0);
    check("rst_kept_old_data", rd, 32'h11);

    // Request dropped right after capture still completes and commits.
    txn(1'b0, 32'h30, 1'b1, 32'hCAFE_F00D, 1'b1, rd, ec, lat, ok);
    model(32'h30, 1'b1, 32'hCAFE_F00D);
    check("drop_latency", lat, 32'd3);
    txn(1'b0, 32'h30, 1'b0, 32'h0, 1'b0, rd, ec, lat, ok);
    model(32'h30, 1'b0, 32'h0);
    check("drop_committed", rd, 32'hCAFE_F00D);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d;
      logic        c;
      if ($urandom_range(0, 3) == 0) a = $urandom | 32'h0000_0400;
      else a = {22'd0, 8'($urandom), 2'($urandom)};
      c = 1'($urandom);
      d = $urandom;
      if (!c && a[31:10] == 22'd0 && !mwr[a[9:2]]) c = 1'b1;
      txn(1'b0, a, c, d, 1'b0, rd, ec, lat, ok);
      model(a, c, d);
      check($sformatf("rand%0d_latency", i), lat, 32'd3);
      check($sformatf("rand%0d_rdata", i), rd, mrd);
      check($sformatf("rand%0d_err", i), {24'd0, ec}, merr);
    end

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      txn(1'b0, 32'h0001_0000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, rd, ec, lat, ok);
      model(32'h0001_0000 + 32'(i * 4), 1'b0, 32'h0);
    end
    check("sat_err_model", {24'd0, ec}, merr);
    check("sat_err_255",   {24'd0, ec}, 32'd255);
    check("sat_rdata",     rd,          32'hDEAD_BEEF);

    // Zero-wait instance: pre-write then back-to-back reads with req held.
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 32'(i * 4), 1'b1, 32'(i + 1), 1'b0, rd, ec, lat, ok);
      check($sformatf("w0_write%0d_latency", i), lat, 32'd1);
    end
    req0 = 1'b1; addr0 = 32'h0; cmd0 = 1'b0;
    k = 0; cyc = 0; last = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ack0) begin
        check($sformatf("w0_b2b_rdata%0d", k), rdata0, 32'(k + 1));
        check($sformatf("w0_b2b_spacing%0d", k), cyc - last, (k == 0) ? 32'd1 : 32'd2);
        last = cyc;
        k++;
        addr0 = 32'(k * 4);
      end
    end
    req0 = 1'b0;
    check("w0_b2b_count", k, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
